sort_frame_streamer: RTL and testbench
======================================

// Module: sort_frame_streamer
// PURPOSE
//  Reader/unpacker on the output side of the 8-lane pipelined sort network.
//  - Accepts one packed sorted frame (N elements of W bits) per valid/ready transfer.
//  - Buffers up to two frames (ping-pong).
//  - Emits the elements one per beat, smallest-lane first, on a valid/ready stream.
//  - Checks each emitted element against the previous one in the same frame and
//    flags and counts any ordering violation.
// PARAMETERS
//  W      3   element width in bits
//  N      8   elements per frame; power of two, >=2
//  CNT_W  8   width of the frame and error counters
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  reset      in   1      synchronous, active-high reset
//  in_frame   in   W*N    packed frame; element k = in_frame[W*N-1-W*k -: W] (element 0 in MSBs)
//  in_valid   in   1      in_frame is valid this cycle
//  in_ready   out  1      a frame slot is free
//  out_data   out  W      current element
//  out_index  out  log2N  element index within the frame, 0..N-1
//  out_last   out  1      out_index == N-1
//  out_err    out  1      out_index != 0 and out_data < previous element of the same frame
//  out_valid  out  1      out_* fields are valid
//  out_ready  in   1      consumer accepts the beat
//  frames_done out CNT_W  number of fully emitted frames; wraps
//  err_count  out  CNT_W  number of out_err beats accepted; saturates at all-ones
// BEHAVIOUR
//  Reset (synchronous, active-high; clock and reset are fixed as above):
//  - Clears both slots, the write and read pointers, occupancy (0), out_index (0),
//    the previous-element register, frames_done and err_count.
//  - Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_err=0, out_last=0.
//  - A reset asserted mid-frame discards all buffered and partially emitted frames;
//    no beat is emitted in the reset cycle.
//  Occupancy (2-bit register, 0..2):
//  - in_ready = (occ != 2), driven from the registered occupancy only.
//  - out_valid = (occ != 0).
//  Push: in_valid && in_ready writes in_frame into the slot at wr_ptr, toggles wr_ptr, occ+1.
//  Beat: out_valid && out_ready.
//  - If out_index != N-1: out_index+1, and prev <= out_data.
//  - If out_index == N-1 (pop): out_index <= 0, toggle rd_ptr, occ-1, frames_done+1.
//  - Simultaneous push and pop: occ unchanged.
//  - A pop while full frees the slot on the next cycle; it is not a same-cycle bypass.
//  Latency:
//  - A frame pushed into an empty buffer at edge t presents element 0 with out_valid=1
//    after edge t, so beat 0 can complete at edge t+1.
//  - Throughput: N beats per frame. With out_ready held high the output never bubbles
//    between back-to-back frames.
//  Output fields:
//  - out_data, out_index and out_last are combinational selects from the read slot and
//    out_index. Each is zero when occ==0.
//  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
//  Order check:
//  - out_err is combinational: (out_index!=0) && (out_data < prev), unsigned compare.
//  - prev is cleared at each frame start. Equal elements are legal.
//  - err_count increments on each accepted beat with out_err=1 and holds at 2^CNT_W-1.
//  - frames_done wraps modulo 2^CNT_W.
//  - in_frame is sampled only on a push; it is ignored at all other times.
// TESTING
//  1. Reset, push 24'h053977 (0..7 ascending), out_ready=1
//     -> beats out_data 0,1,...,7; out_index 0..7; out_last only on beat 7; out_err=0;
//        frames_done=1; err_count=0.
//  2. Push 24'hFAC688 (7..0 descending)
//     -> out_data 7,6,...,0; out_err=1 on beats 1..7; err_count=7.
//  3. out_ready=0 with three frames offered
//     -> two frames accepted, then in_ready=0 and the third frame is held off;
//        out_* stable; after one frame drains (8 beats), in_ready=1 the next cycle.
//  4. Back-to-back frames 24'h053977 then 24'h000000 with out_ready=1
//     -> 16 consecutive valid beats with no bubble; beat 8 has out_index=0 and out_err=0
//        (prev cleared at frame start).
//  5. Assert reset after beat 3 of a frame with a second frame buffered
//     -> next cycle: out_valid=0, in_ready=1, counters 0; the next pushed frame
//        starts at index 0.
//  6. Run 300 descending frames
//     -> err_count saturates at 8'hFF; frames_done wraps to 8'd44.

Source files
------------

// File: rtl/sort_frame_streamer.sv
// Output-side unpacker for the sort network: ping-pong buffers two packed frames
// and streams their elements one per beat, checking ascending order within a frame.
module sort_frame_streamer #(
    parameter  int unsigned W     = 3,
    parameter  int unsigned N     = 8,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned IW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W*N-1:0]   in_frame,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out_data,
    output logic [IW-1:0]    out_index,
    output logic             out_last,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frames_done,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned FW = W * N;

    logic [FW-1:0] slot0;
    logic [FW-1:0] slot1;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;
    logic [IW-1:0] idx;
    logic [W-1:0]  prev;

    logic [FW-1:0] rd_frame;
    logic [FW-1:0] shifted;
    logic [W-1:0]  elem;
    logic          push;
    logic          beat;
    logic          pop;

    // Element select: shift the addressed element up into the MSBs.
    always_comb begin
        rd_frame  = rd_ptr ? slot1 : slot0;
        shifted   = rd_frame << (W * idx);
        elem      = shifted[FW-1 -: W];
        out_valid = (occ != 2'd0);
        in_ready  = (occ != 2'd2);
        out_data  = out_valid ? elem : '0;
        out_index = out_valid ? idx : '0;
        out_last  = out_valid && (idx == IW'(N - 1));
        out_err   = out_valid && (idx != '0) && (elem < prev);
        push      = in_valid && in_ready;
        beat      = out_valid && out_ready;
        pop       = beat && out_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0       <= '0;
            slot1       <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
            idx         <= '0;
            prev        <= '0;
            frames_done <= '0;
            err_count   <= '0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    slot1 <= in_frame;
                end else begin
                    slot0 <= in_frame;
                end
                wr_ptr <= ~wr_ptr;
            end

            // prev restarts at zero with every frame so element 0 never flags.
            if (beat) begin
                if (pop) begin
                    idx         <= '0;
                    prev        <= '0;
                    rd_ptr      <= ~rd_ptr;
                    frames_done <= frames_done + CNT_W'(1);
                end else begin
                    idx  <= idx + IW'(1);
                    prev <= out_data;
                end
            end

            if (beat && out_err && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end

            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_frame_streamer.sv
// Directed bench for sort_frame_streamer: a scoreboard queue of expected beats is filled
// on each accepted frame and checked against the stream, alongside an occupancy/counter model.
module tb_sort_frame_streamer;

    localparam int unsigned W     = 3;
    localparam int unsigned N     = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IW    = 3;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
        logic          last;
        logic          err;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [W*N-1:0]   in_frame;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     out_data;
    logic [IW-1:0]    out_index;
    logic             out_last;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] frames_done;
    logic [CNT_W-1:0] err_count;

    sort_frame_streamer #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_frame   (in_frame),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frames_done(frames_done),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    exp_occ = 0;
    int    exp_frames = 0;
    int    exp_errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model at negedge, advance the model, return after posedge.
    task automatic step();
        beat_t b;
        beat_t nb;
        logic  pushing;
        logic  popping;
        logic [W-1:0] e;
        logic [W-1:0] pe;
        @(negedge clk);
        if (reset) begin
            q.delete();
            exp_occ    = 0;
            exp_frames = 0;
            exp_errs   = 0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(exp_occ != 2));
            chk("out_valid", 32'(out_valid), 32'(exp_occ != 0));
            chk("frames_done", 32'(frames_done), 32'(exp_frames % 256));
            chk("err_count", 32'(err_count), 32'(exp_errs));
            pushing = in_valid && (exp_occ != 2);
            popping = 1'b0;
            if (exp_occ == 0) begin
                chk("idle_data", 32'(out_data), 32'd0);
                chk("idle_last", 32'(out_last), 32'd0);
                chk("idle_err", 32'(out_err), 32'd0);
            end else if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL scoreboard: observed empty queue expected a pending beat");
            end else begin
                b = q[0];
                chk("out_data", 32'(out_data), 32'(b.data));
                chk("out_index", 32'(out_index), 32'(b.idx));
                chk("out_last", 32'(out_last), 32'(b.last));
                chk("out_err", 32'(out_err), 32'(b.err));
                if (out_ready) begin
                    void'(q.pop_front());
                    if (b.last) begin
                        popping = 1'b1;
                        exp_frames++;
                    end
                    if (b.err && exp_errs != 255) exp_errs++;
                end
            end
            if (pushing) begin
                pe = '0;
                for (int k = 0; k < int'(N); k++) begin
                    e       = in_frame[W*N-1-W*k -: W];
                    nb.data = e;
                    nb.idx  = IW'(k);
                    nb.last = (k == int'(N) - 1);
                    nb.err  = (k != 0) && (e < pe);
                    q.push_back(nb);
                    pe = e;
                end
            end
            if (pushing && !popping) exp_occ++;
            if (!pushing && popping) exp_occ--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer a frame until accepted (bounded), then drop in_valid.
    task automatic offer(input logic [W*N-1:0] f);
        logic took;
        took     = 1'b0;
        in_frame = f;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !took; i++) begin
            took = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!took) begin
            n_cmp++;
            n_err++;
            $error("FAIL offer_timeout: observed in_ready=0 expected frame accepted");
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_frame  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        run(2);
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);

        // Ascending frame.
        out_ready = 1'b1;
        offer(24'h053977);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_index", 32'(out_index), 32'd0);
        run(10);
        chk("t1_frames", 32'(frames_done), 32'd1);
        chk("t1_errs", 32'(err_count), 32'd0);

        // Descending frame.
        offer(24'hFAC688);
        run(10);
        chk("t2_errs", 32'(err_count), 32'd7);

        // Backpressure: third frame held off until a slot frees.
        out_ready = 1'b0;
        offer(24'h053977);
        offer(24'hFAC688);
        in_frame = 24'h000000;
        in_valid = 1'b1;
        run(3);
        chk("t3_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        offer(24'h000000);
        run(30);

        // Back-to-back frames with no bubble.
        in_frame = 24'h053977;
        in_valid = 1'b1;
        step();
        in_frame = 24'h000000;
        step();
        in_valid = 1'b0;
        run(18);

        // Reset mid-frame with a second frame buffered.
        offer(24'hFAC688);
        offer(24'h053977);
        run(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd1);
        chk("t5_frames", 32'(frames_done), 32'd0);
        chk("t5_errs", 32'(err_count), 32'd0);
        offer(24'h053977);
        chk("t5_index", 32'(out_index), 32'd0);
        run(10);

        // Saturation and wrap over 300 descending frames.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 300; i++) offer(24'hFAC688);
        run(20);
        chk("t6_errs_sat", 32'(err_count), 32'hFF);
        chk("t6_frames_wrap", 32'(frames_done), 32'd44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
